// File: rtl/sp_ram_access_ctrl.sv
// Request/response front end for a single-port synchronous RAM: one request at a time,
// sequences addr/cs/we/oe and owns the direction of the shared data bus.
module sp_ram_access_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  wr_done,
    output logic                  wr_err,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic [2:0]            dbg_state
);

    // Handshakes: a request transfers on a rising edge where req_valid && req_ready, a
    // response where rsp_valid && rsp_ready; an offered item is held stable until it transfers.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RSP  = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    drive_en;
    logic                    in_range;

    assign in_range  = ({1'b0, req_addr} < DEPTH_L);
    assign dbg_state = state;

    // The only driver of the RAM bus from this side; released in every state but WR.
    assign ram_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        err_q   <= 1'b0;
                    end
                end
                RD2: rdata_q <= ram_data;
                ERR: begin
                    if (!we_q) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        wr_done    = 1'b0;
        wr_err     = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        ram_addr   = '0;
        ram_cs     = 1'b0;
        ram_we     = 1'b0;
        ram_oe     = 1'b0;
        drive_en   = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted even though the state already reads IDLE.
                req_ready = !rst;
                if (req_valid) begin
                    if (!in_range)   state_next = ERR;
                    else if (req_we) state_next = WR;
                    else             state_next = RD1;
                end
            end
            WR: begin
                ram_cs     = 1'b1;
                ram_we     = 1'b1;
                ram_addr   = addr_q;
                drive_en   = 1'b1;
                wr_done    = 1'b1;
                state_next = IDLE;
            end
            RD1: begin
                ram_cs     = 1'b1;
                ram_oe     = 1'b1;
                ram_addr   = addr_q;
                state_next = RD2;
            end
            RD2: begin
                ram_cs     = 1'b1;
                ram_oe     = 1'b1;
                ram_addr   = addr_q;
                state_next = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                if (rsp_ready) state_next = IDLE;
            end
            ERR: begin
                if (we_q) begin
                    wr_done    = 1'b1;
                    wr_err     = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = RSP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sp_ram_access_ctrl.sv
// Bench for sp_ram_access_ctrl with a behavioural synchronous RAM on the shared bus and a
// word-array reference model of what the memory should hold.
module tb_sp_ram_access_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          wr_done;
    logic          wr_err;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] ram_addr;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;
    wire  [DW-1:0] ram_data;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic          exp_err_q[$];
    logic [DW-1:0] model_mem[16];
    logic [DW-1:0] z_word;
    logic          bus_chk_en = 1'b0;

    // RAM stand-in: write on cs&we, capture on cs&!we, drive bus while cs&oe&!we.
    logic [DW-1:0] ram_mem[16] = '{default: '0};
    logic [DW-1:0] ram_rd_q    = '0;

    sp_ram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .wr_done(wr_done), .wr_err(wr_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_data(ram_data), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
        if (ram_cs && !ram_we) ram_rd_q <= ram_mem[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_rd_q : {DW{1'bz}};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bus rules, sampled mid-cycle
    always @(negedge clk) begin
        if (bus_chk_en) begin
            check("bus_we_and_oe", 32'(ram_we & ram_oe), 32'd0);
            if (!ram_we && !(ram_cs && ram_oe)) check("bus_released", ram_data, z_word);
            if (ram_cs && ram_oe) check("bus_rd_known", 32'($isunknown(ram_data)), 32'd0);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
        check({tag, "_wr_done"},   32'(wr_done), 32'd0);
        check({tag, "_wr_err"},    32'(wr_err), 32'd0);
        check({tag, "_ram_pins"},  {26'd0, ram_addr, ram_cs, ram_we}, 32'd0);
        check({tag, "_ram_oe"},    32'(ram_oe), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_ram_data"},  ram_data, z_word);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit in_range;
        in_range = int'(a) < DEPTH;
        wait_ready("wr");
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
        check("wr_done", 32'(wr_done), 32'd1);
        check("wr_err", 32'(wr_err), 32'(!in_range));
        check("wr_cs", 32'(ram_cs), 32'(in_range));
        if (in_range) model_mem[a] = d;
        tick();
        check("wr_done_pulse", 32'(wr_done), 32'd0);
        check("wr_back_ready", 32'(req_ready), 32'd1);
    endtask

    // hold: cycles of rsp_ready=0 once the response shows; poke: offer a write meanwhile
    task automatic do_read(input logic [AW-1:0] a, input int hold, input bit poke);
        bit            in_range;
        int            lat;
        logic [DW-1:0] exp_d;
        logic          exp_e;
        in_range = int'(a) < DEPTH;
        wait_ready("rd");
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = $urandom;
        tick();
        req_valid = 1'b0;
        exp_q.push_back(in_range ? model_mem[a] : '0);
        exp_err_q.push_back(!in_range);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            check("rd_cs_only_in_range", 32'(ram_cs), 32'(in_range));
            tick();
            lat++;
        end
        // edges counted from the accept edge: RD1, RD2, RSP -> 3; ERR, RSP -> 2
        check("rd_latency", 32'(lat), in_range ? 32'd3 : 32'd2);
        exp_d = exp_q.pop_front();
        exp_e = exp_err_q.pop_front();
        check("rd_rdata", rsp_rdata, exp_d);
        check("rd_err", 32'(rsp_err), 32'(exp_e));
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 32'hdead_beef;
            end
            tick();
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, exp_d);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_no_accept", {30'd0, wr_done, ram_cs}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd_released", 32'(rsp_valid), 32'd0);
        check("rd_back_ready", 32'(req_ready), 32'd1);
    endtask

    // stimulus and scoreboard
    initial begin
        logic [AW-1:0] ra;
        z_word    = {DW{1'bz}};
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        #1;
        check_quiet("por");
        bus_chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
        check("por_ready", 32'(req_ready), 32'd1);

        // two writes then two reads
        do_write(4'd2, 32'd52);
        do_write(4'd3, 32'd20);
        do_read(4'd2, 0, 1'b0);
        do_read(4'd3, 0, 1'b0);

        // backpressure with a concurrent, ignored write offer to address 5
        do_read(4'd2, 5, 1'b1);
        do_read(4'd5, 0, 1'b0);

        // out-of-range write and read, then the top in-range word
        do_write(4'd13, 32'd7);
        do_read(4'd14, 0, 1'b0);
        do_write(4'd11, 32'd99);
        do_read(4'd11, 1, 1'b0);

        // reset while a response is pending
        wait_ready("mid");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("mid_in_rsp", 32'(rsp_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        check_quiet("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("mid_ready", 32'(req_ready), 32'd1);
        check("mid_no_rsp", 32'(rsp_valid), 32'd0);

        // reset during RD2, then the memory still holds its data
        wait_ready("rd2");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
        tick();
        req_valid = 1'b0;
        tick();
        check("rd2_cs", 32'(ram_cs & ram_oe), 32'd1);
        #3 rst = 1'b1;
        #1;
        check_quiet("rd2_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd2_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_read(4'd3, 0, 1'b0);

        // randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            ra = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write(ra, $urandom);
            else do_read(ra, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // final report
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
